// File: rtl/vroom_pll_sup_pkg.sv
// Shared types, default parameters and width helpers for the PLL lock supervisor.
package vroom_pll_sup_pkg;

  typedef enum logic [1:0] {
    StPllRst   = 2'd0,
    StWaitLock = 2'd1,
    StStable   = 2'd2,
    StRun      = 2'd3
  } pll_sup_state_e;

  localparam int unsigned DefSyncStages         = 2;
  localparam int unsigned DefPllRstCycles       = 16;
  localparam int unsigned DefLockStableCycles   = 1024;
  localparam int unsigned DefRelockTimeoutCycles = 65536;
  localparam int unsigned DefCntW               = 16;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/vroom_bit_sync.sv
// N-stage single-bit synchronizer with asynchronous active-low clear; STAGES must be >= 2.
module vroom_bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/vroom_system_pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier on the reference clock.
// Optional PLL re-reset on relock timeout: define VROOM_PLL_AUTO_RELOCK_EN.
module vroom_system_pll_lock_supervisor
  import vroom_pll_sup_pkg::*;
#(
  parameter int unsigned SYNC_STAGES           = DefSyncStages,
  parameter int unsigned PLL_RST_CYCLES        = DefPllRstCycles,
  parameter int unsigned LOCK_STABLE_CYCLES    = DefLockStableCycles,
  parameter int unsigned RELOCK_TIMEOUT_CYCLES = DefRelockTimeoutCycles,
  parameter int unsigned CNT_W                 = DefCntW
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_reset_n,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_loss_count,
  input  logic             clear_count
);

  // One timer is shared by all states; it is cleared on every state change.
`ifdef VROOM_PLL_AUTO_RELOCK_EN
  localparam int unsigned TimerSpan =
      max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES), RELOCK_TIMEOUT_CYCLES);
`else
  localparam int unsigned TimerSpan = max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES);
`endif
  localparam int unsigned TimerW = cnt_width(TimerSpan);

  localparam logic [TimerW-1:0] RstLast    = TimerW'(PLL_RST_CYCLES - 1);
  localparam logic [TimerW-1:0] StableLast = TimerW'(LOCK_STABLE_CYCLES - 1);
`ifdef VROOM_PLL_AUTO_RELOCK_EN
  localparam logic [TimerW-1:0] RelockLast = TimerW'(RELOCK_TIMEOUT_CYCLES - 1);
`endif

  pll_sup_state_e    state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0]  loss_cnt_q, loss_cnt_d;
  logic              pll_rst_q, sys_reset_n_q, ready_q;
  logic              locked_s;
  logic              loss_event;

  vroom_bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_locked_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (pll_locked),
    .q       (locked_s)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    loss_event = 1'b0;
    unique case (state_q)
      StPllRst: begin
        if (timer_q == RstLast) begin
          state_d = StWaitLock;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d = StStable;
          timer_d = '0;
        end
`ifdef VROOM_PLL_AUTO_RELOCK_EN
        else if (timer_q == RelockLast) begin
          state_d = StPllRst;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      StStable: begin
        // Any low sample restarts qualification from scratch.
        if (!locked_s) begin
          state_d = StWaitLock;
          timer_d = '0;
        end else if (timer_q == StableLast) begin
          state_d = StRun;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d    = StWaitLock;
          timer_d    = '0;
          loss_event = 1'b1;
        end
      end
      default: begin
        state_d = StPllRst;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (clear_count) begin
      loss_cnt_d = '0;
    end else if (loss_event && !(&loss_cnt_q)) begin
      loss_cnt_d = loss_cnt_q + 1'b1;
    end
  end

  // Outputs are registered from the next state so they change on the same edge as state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StPllRst;
      timer_q       <= '0;
      loss_cnt_q    <= '0;
      pll_rst_q     <= 1'b1;
      sys_reset_n_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      loss_cnt_q    <= loss_cnt_d;
      pll_rst_q     <= (state_d == StPllRst);
      sys_reset_n_q <= (state_d == StRun);
      ready_q       <= (state_d == StRun);
    end
  end

  assign pll_rst         = pll_rst_q;
  assign sys_reset_n     = sys_reset_n_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_vroom_system_pll_lock_supervisor.sv
// Self-checking bench: directed scenarios plus randomized lock traffic against a behavioural model.
module tb_vroom_system_pll_lock_supervisor;

  localparam int unsigned SYNC = 2;
  localparam int unsigned PRC  = 4;
  localparam int unsigned LSC  = 8;
  localparam int unsigned RTC  = 32;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;

  localparam int SPllRst = 0;
  localparam int SWait   = 1;
  localparam int SStable = 2;
  localparam int SRun    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pll_locked = 1'b0;
  logic          clear_count = 1'b0;
  logic          pll_rst;
  logic          sys_reset_n;
  logic          ready;
  logic [1:0]    state;
  logic [CW-1:0] lock_loss_count;

  vroom_system_pll_lock_supervisor #(
    .SYNC_STAGES           (SYNC),
    .PLL_RST_CYCLES        (PRC),
    .LOCK_STABLE_CYCLES    (LSC),
    .RELOCK_TIMEOUT_CYCLES (RTC),
    .CNT_W                 (CW)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pll_locked      (pll_locked),
    .pll_rst         (pll_rst),
    .sys_reset_n     (sys_reset_n),
    .ready           (ready),
    .state           (state),
    .lock_loss_count (lock_loss_count),
    .clear_count     (clear_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: phase plus plain cycle counters, synchronizer as a delay line.
  int m_state;
  int m_cnt;
  int m_rst_cycles;
  int m_wait;
  int m_good;
  bit m_sync[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state      = SPllRst;
    m_cnt        = 0;
    m_rst_cycles = 0;
    m_wait       = 0;
    m_good       = 0;
    m_sync       = {};
    repeat (SYNC) m_sync.push_back(1'b0);
  endtask

  task automatic model_step();
    bit ls;
    bit ev;
    ls = m_sync[SYNC-1];
    m_sync.push_front(pll_locked);
    void'(m_sync.pop_back());
    ev = 1'b0;
    case (m_state)
      SPllRst: begin
        m_rst_cycles++;
        if (m_rst_cycles == PRC) begin
          m_state = SWait;
          m_wait  = 0;
        end
      end
      SWait: begin
        if (ls) begin
          m_state = SStable;
          m_good  = 0;
        end else begin
          m_wait++;
`ifdef VROOM_PLL_AUTO_RELOCK_EN
          if (m_wait == RTC) begin
            m_state      = SPllRst;
            m_rst_cycles = 0;
          end
`endif
        end
      end
      SStable: begin
        if (!ls) begin
          m_state = SWait;
          m_wait  = 0;
        end else begin
          m_good++;
          if (m_good == LSC) m_state = SRun;
        end
      end
      default: begin
        if (!ls) begin
          m_state = SWait;
          m_wait  = 0;
          ev      = 1'b1;
        end
      end
    endcase
    if (clear_count) m_cnt = 0;
    else if (ev && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic compare_outputs();
    check("state", state, m_state);
    check("pll_rst", pll_rst, m_state == SPllRst);
    check("sys_reset_n", sys_reset_n, m_state == SRun);
    check("ready", ready, m_state == SRun);
    check("lock_loss_count", lock_loss_count, m_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_outputs();
  endtask

  // Assert reset mid-cycle, check values asynchronously, release well before the next edge.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("rst_pll_rst", pll_rst, 1);
    check("rst_sys_reset_n", sys_reset_n, 0);
    check("rst_ready", ready, 0);
    check("rst_count", lock_loss_count, 0);
    check("rst_state", state, SPllRst);
    model_reset();
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_run(input string tag, input int budget);
    for (int i = 0; i < budget && m_state != SRun; i++) tick();
    check(tag, ready, 1);
  endtask

  // Drop lock until sys_reset_n falls, then restore and requalify.
  task automatic drop_and_recover();
    int n;
    pll_locked = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n++;
      if (!sys_reset_n) break;
    end
    pll_locked = 1'b1;
    check("drop_latency", n, SYNC + 1);
    wait_run("requalify_run", 60);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int stable_cycles;
    bit saw_wait;

    model_reset();

    // Power-up with lock held high.
    pll_locked = 1'b1;
    do_reset();
    n = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pll_rst) n++;
      else break;
    end
    check("pll_rst_len", n, PRC);
    wait_run("first_run", 40);
    check("first_count", lock_loss_count, 0);

    // Lock drop partway through qualification.
    do_reset();
    for (int i = 0; i < 40 && !(m_state == SStable && m_good == 5); i++) tick();
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    saw_wait = 1'b0;
    stable_cycles = 0;
    for (int i = 0; i < 60 && state != 2'(SRun); i++) begin
      tick();
      if (state == 2'(SWait)) saw_wait = 1'b1;
      if (saw_wait && state == 2'(SStable)) stable_cycles++;
    end
    check("stable_requalify", stable_cycles, LSC);
    check("stable_drop_count", lock_loss_count, 0);

    // Three lock losses from RUN.
    for (int k = 0; k < 3; k++) drop_and_recover();
    check("loss_count_3", lock_loss_count, 3);

    // Saturation, then clear colliding with an increment.
    for (int k = 0; k < 17; k++) drop_and_recover();
    check("loss_count_sat", lock_loss_count, CMAX);
    pll_locked = 1'b0;
    tick();
    tick();
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    check("clear_wins", lock_loss_count, 0);
    check("clear_state", state, SWait);
    pll_locked = 1'b1;
    wait_run("after_clear_run", 60);

    // Randomized lock traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      if (pll_locked) begin
        if ($urandom_range(0, 29) == 0) pll_locked = 1'b0;
      end else begin
        if ($urandom_range(0, 3) == 0) pll_locked = 1'b1;
      end
      clear_count = ($urandom_range(0, 63) == 0);
      tick();
    end
    clear_count = 1'b0;

    // No lock at all: timeout behaviour.
    pll_locked = 1'b0;
    do_reset();
    repeat (PRC + RTC) tick();
`ifdef VROOM_PLL_AUTO_RELOCK_EN
    check("relock_pulse", pll_rst, 1);
    check("relock_state", state, SPllRst);
`else
    check("relock_pulse", pll_rst, 0);
    check("relock_state", state, SWait);
`endif
    repeat (80) tick();

    // Asynchronous reset from RUN, then a full new sequence.
    pll_locked = 1'b1;
    do_reset();
    wait_run("pre_reset_run", 40);
    drop_and_recover();
    do_reset();
    check("post_reset_count", lock_loss_count, 0);
    wait_run("post_reset_run", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
